inst_fetch_unit: RTL

Front end of the uDLX pipeline. Owns the program counter and drives the instruction SRAM request/acknowledge interface. Buffers fetched words in a small prefetch FIFO and presents {pc+4, instruction} to the fetch/decode pipeline register. Honours decode-stage stall and branch/flush redirects, including discard of a stale in-flight fetch.

---
 rtl/inst_fetch_unit_if.sv | 17 +
 rtl/inst_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction SRAM request/acknowledge bundle between the fetch unit (master)
// and the instruction memory (slave).
interface inst_fetch_unit_if #(
  parameter int PC_DATA_WIDTH     = 20,
  parameter int INSTRUCTION_WIDTH = 32
);
  // Handshake: imem_req/imem_addr are raised by the master and held stable until
  // the cycle imem_ack=1; imem_ack is only meaningful while imem_req=1 and carries
  // imem_rdata for that same cycle (zero-wait acks are allowed).
  logic                         imem_req;
  logic [PC_DATA_WIDTH-1:0]     imem_addr;
  logic                         imem_ack;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// uDLX fetch front end: PC, SRAM request handshake, prefetch FIFO, flush/drop handling.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter int                     PC_DATA_WIDTH     = 20,
  parameter int                     INSTRUCTION_WIDTH = 32,
  parameter int                     FIFO_DEPTH        = 2,
  parameter logic [PC_DATA_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [PC_DATA_WIDTH-1:0]     branch_target,
  inst_fetch_unit_if.master            imem,
  output logic                         inst_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic [PC_DATA_WIDTH-1:0]     new_pc_out,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  fetch_count,
  output logic                         dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_FETCH, S_DROP} state_e;

  state_e                       state_q, state_d;
  logic [PC_DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [PC_DATA_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic                         outstanding_q, outstanding_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [PC_DATA_WIDTH-1:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];

  logic                         req;
  logic                         push;
  logic                         pop;
  logic [PC_DATA_WIDTH-1:0]     pc_plus4;
  logic [PC_DATA_WIDTH-1:0]     target_aligned;
  logic                         unused_target_lsbs;

  assign pc_plus4           = pc_q + PC_DATA_WIDTH'(4);
  assign target_aligned     = {branch_target[PC_DATA_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  assign inst_valid      = (count_q != '0);
  assign instruction_out = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign new_pc_out      = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign dbg_state_o     = (state_q == S_DROP);

  assign imem.imem_req  = req;
  assign imem.imem_addr = outstanding_q ? req_addr_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    req           = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    // A flush never starts a fresh request in its own cycle; the target goes out next cycle.
    if (state_q == S_DROP) begin
      req = 1'b1;
    end else begin
      req = outstanding_q | (~flush & (count_q < DEPTH_C));
    end
    if (rst) req = 1'b0;

    if (req && !outstanding_q) req_addr_d = pc_q;
    outstanding_d = req & ~imem.imem_ack;

    push = (state_q == S_FETCH) & req & imem.imem_ack & ~flush;
    pop  = inst_valid & ~stall & ~flush;

    if (push) pc_d = pc_plus4;

    case (state_q)
      S_FETCH: if (flush && req && !imem.imem_ack) state_d = S_DROP;
      S_DROP:  if (imem.imem_ack) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase

    if (flush) begin
      pc_d     = target_aligned;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pc_plus4;
      fifo_inst_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fetch_count_q  <= '0;
    end else begin
      if (inst_valid && stall) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (push)                fetch_count_q  <= fetch_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fetch_count  = fetch_count_q;
`else
  assign stall_cycles = '0;
  assign fetch_count  = '0;
`endif

endmodule
